// File: rtl/difftest_log_pkg.sv
// Shared types for the performance-event logger: report payload, log levels, cycle width.
package difftest_log_pkg;

  localparam int unsigned CYCLE_W     = 64;
  localparam int unsigned COREID_W    = 8;
  localparam int unsigned DELTA_MAX_W = 64;

  typedef enum logic [1:0] {
    Debug,
    Info,
    Warning,
    Error
  } LogLevel;

  // Delta is held at its widest legal size; the top keeps only CNT_W bits.
  typedef struct packed {
    logic [COREID_W-1:0]    coreid;
    logic [CYCLE_W-1:0]     total;
    logic [DELTA_MAX_W-1:0] delta;
    logic [CYCLE_W-1:0]     cycle;
  } log_report_t;

endpackage

// File: rtl/difftest_log_event_if.sv
// Report channel of difftest_log_event: valid/ready handshake plus captured fields.
interface difftest_log_event_if #(
  parameter int unsigned CNT_W = 32
);
  import difftest_log_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [COREID_W-1:0] out_coreid;
  logic [CYCLE_W-1:0]  out_total;
  logic [CNT_W-1:0]    out_delta;
  logic [CYCLE_W-1:0]  out_cycle;

  modport master (
    output out_valid, out_coreid, out_total, out_delta, out_cycle,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_coreid, out_total, out_delta, out_cycle,
    output out_ready
  );

endinterface

// File: rtl/log_interval_timer.sv
// Free-running 0..INTERVAL-1 counter with a one-cycle trigger on the last count.
// INTERVAL = 0 parks the counter at 0 and never triggers.
module log_interval_timer #(
  parameter int unsigned INTERVAL = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic o_trigger_c
);

  localparam int unsigned TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TMR_W-1:0] LAST = TMR_W'((INTERVAL == 0) ? 0 : INTERVAL - 1);

  logic [TMR_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap      = (r_cnt == LAST);
  assign o_trigger_c = (INTERVAL != 0) && w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/difftest_log_event.sv
// Samples a free-running event counter, accumulates it, and emits periodic/on-demand reports.
// Define LOG_EVENT_DISPLAY_EN to print every accepted report in simulation.
module difftest_log_event
  import difftest_log_pkg::*;
#(
  parameter string       NAME     = "event",
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned INTERVAL = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COREID_W-1:0]         coreid,
  input  logic [CNT_W-1:0]            value,
  input  logic                        dump_req,
  difftest_log_event_if.master        o_rpt
);

  logic [CYCLE_W-1:0] r_cycle_cnt;
  logic [CYCLE_W-1:0] r_total;
  logic [CNT_W-1:0]   r_prev_value;
  logic [CNT_W-1:0]   r_last_value;
  logic [CNT_W-1:0]   r_cap_value;
  logic               r_pending;
  logic               r_valid;
  log_report_t        r_report;

  logic               w_trigger;
  logic               w_req;
  logic               w_capture;
  logic               w_accept;
  logic [CNT_W-1:0]   w_step;
  logic [CNT_W-1:0]   w_delta;
  logic               w_unused_delta;

  log_interval_timer #(
    .INTERVAL (INTERVAL)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_trigger_c (w_trigger)
  );

  // Modular subtraction makes counter wrap-around a small positive step.
  assign w_step    = value - r_prev_value;
  assign w_delta   = value - r_last_value;
  assign w_req     = w_trigger | dump_req;
  assign w_capture = r_pending & ~r_valid;
  assign w_accept  = r_valid & o_rpt.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt  <= '0;
      r_total      <= '0;
      r_prev_value <= '0;
    end else begin
      r_cycle_cnt  <= r_cycle_cnt + CYCLE_W'(1);
      r_total      <= r_total + CYCLE_W'(w_step);
      r_prev_value <= value;
    end
  end

  // A request on the capture or handshake edge stays pending so nothing is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending    <= 1'b0;
      r_valid      <= 1'b0;
      r_last_value <= '0;
      r_cap_value  <= '0;
      r_report     <= '0;
    end else begin
      r_pending <= w_req | (r_pending & ~w_capture);
      if (w_capture) begin
        r_valid         <= 1'b1;
        r_cap_value     <= value;
        r_report.coreid <= coreid;
        r_report.total  <= r_total;
        r_report.delta  <= DELTA_MAX_W'(w_delta);
        r_report.cycle  <= r_cycle_cnt;
      end else if (w_accept) begin
        r_valid      <= 1'b0;
        r_last_value <= r_cap_value;
      end
    end
  end

  assign o_rpt.out_valid  = r_valid;
  assign o_rpt.out_coreid = r_report.coreid;
  assign o_rpt.out_total  = r_report.total;
  assign o_rpt.out_delta  = r_report.delta[CNT_W-1:0];
  assign o_rpt.out_cycle  = r_report.cycle;
  assign w_unused_delta   = ^r_report.delta;

`ifdef LOG_EVENT_DISPLAY_EN
  always @(posedge clk) begin
    if (rst && w_accept) begin
      $display("[%0d] core%0d %s: total=%0d delta=%0d", r_report.cycle, r_report.coreid,
               NAME, r_report.total, r_report.delta[CNT_W-1:0]);
    end
  end
`else
  localparam string unused_name = NAME;
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Randomized bench for difftest_log_event: two instances (INTERVAL=4 and INTERVAL=0)
// compared every cycle against a transaction-level reference model.
module tb_difftest_log_event;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IV0   = 4;
  localparam int unsigned IV1   = 0;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       coreid;
  logic [CNT_W-1:0] value;
  logic             dmp [2];
  logic             rdy [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  difftest_log_event_if #(.CNT_W(CNT_W)) if0 ();
  difftest_log_event_if #(.CNT_W(CNT_W)) if1 ();

  assign if0.out_ready = rdy[0];
  assign if1.out_ready = rdy[1];

  difftest_log_event #(.NAME("ev_periodic"), .CNT_W(CNT_W), .INTERVAL(IV0)) dut0 (
    .clk(clk), .rst(rst), .coreid(coreid), .value(value), .dump_req(dmp[0]), .o_rpt(if0)
  );

  difftest_log_event #(.NAME("ev_dump"), .CNT_W(CNT_W), .INTERVAL(IV1)) dut1 (
    .clk(clk), .rst(rst), .coreid(coreid), .value(value), .dump_req(dmp[1]), .o_rpt(if1)
  );

  // Reference model state (shared counters + one report slot per instance)
  logic [63:0]      m_cyc, m_total;
  logic [CNT_W-1:0] m_prev;
  logic             m_pend  [2];
  logic             m_valid [2];
  logic [CNT_W-1:0] m_last  [2];
  logic [CNT_W-1:0] m_cap   [2];
  logic [7:0]       m_rcore [2];
  logic [63:0]      m_rtot  [2];
  logic [CNT_W-1:0] m_rdelta[2];
  logic [63:0]      m_rcyc  [2];
  int               n_dump_reports;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at model cycle %0d",
               tag, obs, obs, exp, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc = '0; m_total = '0; m_prev = '0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_valid[k] = 1'b0; m_last[k] = '0; m_cap[k] = '0;
      m_rcore[k] = '0; m_rtot[k] = '0; m_rdelta[k] = '0; m_rcyc[k] = '0;
    end
  endtask

  // One clock edge of behaviour, from the current (pre-edge) inputs
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic        req;
      int unsigned iv;
      iv  = (k == 0) ? IV0 : IV1;
      req = dmp[k];
      if (iv != 0) begin
        if ((m_cyc % 64'(iv)) == 64'(iv - 1)) req = 1'b1;
      end
      if (m_pend[k] && !m_valid[k]) begin
        m_valid[k]  = 1'b1;
        m_rcore[k]  = coreid;
        m_rtot[k]   = m_total;
        m_rdelta[k] = value - m_last[k];
        m_rcyc[k]   = m_cyc;
        m_cap[k]    = value;
        m_pend[k]   = req;
      end else begin
        if (m_valid[k] && rdy[k]) begin
          m_valid[k] = 1'b0;
          m_last[k]  = m_cap[k];
        end
        m_pend[k] = m_pend[k] | req;
      end
    end
    m_total = m_total + 64'(CNT_W'(value - m_prev));
    m_prev  = value;
    m_cyc   = m_cyc + 64'd1;
  endtask

  task automatic compare_all();
    check_eq("valid0", 64'(if0.out_valid), 64'(m_valid[0]));
    if (m_valid[0]) begin
      check_eq("coreid0", 64'(if0.out_coreid), 64'(m_rcore[0]));
      check_eq("total0",  if0.out_total,        m_rtot[0]);
      check_eq("delta0",  64'(if0.out_delta),  64'(m_rdelta[0]));
      check_eq("cycle0",  if0.out_cycle,        m_rcyc[0]);
    end
    check_eq("valid1", 64'(if1.out_valid), 64'(m_valid[1]));
    if (m_valid[1]) begin
      check_eq("coreid1", 64'(if1.out_coreid), 64'(m_rcore[1]));
      check_eq("total1",  if1.out_total,        m_rtot[1]);
      check_eq("delta1",  64'(if1.out_delta),  64'(m_rdelta[1]));
      check_eq("cycle1",  if1.out_cycle,        m_rcyc[1]);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid0"}, 64'(if0.out_valid), 64'd0);
    check_eq({tag, "_core0"},  64'(if0.out_coreid), 64'd0);
    check_eq({tag, "_total0"}, if0.out_total, 64'd0);
    check_eq({tag, "_delta0"}, 64'(if0.out_delta), 64'd0);
    check_eq({tag, "_cycle0"}, if0.out_cycle, 64'd0);
    check_eq({tag, "_valid1"}, 64'(if1.out_valid), 64'd0);
    check_eq({tag, "_total1"}, if1.out_total, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (if1.out_valid && rdy[1]) n_dump_reports++;
  endtask

  initial begin
    logic [63:0] prev_tot;
    bit          have_prev;
    bit          seen_dump;
    int          waited;

    rst = 1'b0; coreid = '0; value = '0;
    dmp[0] = 1'b0; dmp[1] = 1'b0; rdy[0] = 1'b1; rdy[1] = 1'b1;
    n_dump_reports = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Steady count, periodic reports on dut0, one dump on dut1 at cycle 10
    have_prev = 1'b0; seen_dump = 1'b0;
    for (int i = 0; i < 40; i++) begin
      coreid = 8'($urandom);
      dmp[1] = (m_cyc == 64'd10);
      tick();
      dmp[1] = 1'b0;
      value  = value + 1;
      if (if0.out_valid) begin
        check_eq("step_delta", 64'(if0.out_delta), 64'd4);
        if (have_prev) check_eq("step_total", if0.out_total - prev_tot, 64'd4);
        prev_tot  = if0.out_total;
        have_prev = 1'b1;
      end
      if (if1.out_valid && !seen_dump) begin
        seen_dump = 1'b1;
        check_eq("dump_lat", m_cyc, 64'd12);
        check_eq("dump_cyc", if1.out_cycle, 64'd11);
      end
    end
    check_eq("dump_seen", 64'(seen_dump), 64'd1);

    // Counter wrap: 0xFFFFFFFE -> 0x00000001
    value = 32'hFFFF_FFFE;
    tick();
    value = 32'h0000_0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      value = value + 1;
    end

    // Sink stalled: requests coalesce, fields hold
    rdy[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      value = value + 1;
    end
    rdy[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      value = value + 1;
    end

    // dump_req coinciding with the periodic trigger
    for (int i = 0; i < 4 && (m_cyc % 64'd4) != 64'd3; i++) begin
      tick();
      value = value + 1;
    end
    dmp[0] = 1'b1;
    tick();
    dmp[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      value = value + 1;
    end

    // Random traffic on dut0
    for (int i = 0; i < 160; i++) begin
      value  = value + CNT_W'($urandom_range(0, 7));
      coreid = 8'($urandom);
      dmp[0] = ($urandom_range(0, 7) == 0);
      rdy[0] = ($urandom_range(0, 3) != 0);
      tick();
    end
    dmp[0] = 1'b0;
    check_eq("dump_only_one", 64'(n_dump_reports), 64'd1);

    // Reset while a report is outstanding
    rdy[0] = 1'b0;
    waited = 0;
    while (!if0.out_valid && waited < 20) begin
      tick();
      value = value + 1;
      waited++;
    end
    check_eq("wait_valid", 64'(if0.out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("held_rst");
    rst = 1'b1;
    rdy[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      value = value + 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/difftest_log_event.md
DIFFTEST_LOG_EVENT -- requirements
Module: difftest_log_event

Interface
REQ-001 Parameter NAME, default "event", string label of the performance event, used in reports only.
REQ-002 Parameter CNT_W, default 32, width of the sampled event counter.
REQ-003 Parameter INTERVAL, default 1000, cycles between periodic reports; 0 disables periodic reports.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 coreid  input  8  core index tagged onto every report.
REQ-007 value  input  CNT_W  free-running event counter from the instantiating block.
REQ-008 dump_req  input  1  one-cycle request for an immediate report.
REQ-009 out_ready  input  1  sink accepts the current report.
REQ-010 out_valid  output  1  report available.
REQ-011 out_coreid  output  8  coreid captured with the report.
REQ-012 out_total  output  64  accumulated event count at capture.
REQ-013 out_delta  output  CNT_W  events since the previous accepted report.
REQ-014 out_cycle  output  64  cycle count at capture.

Function
REQ-015 cycle_cnt (64 bit) SHALL increment by 1 every cycle after reset deassertion.
REQ-016 prev_value SHALL register value every cycle; step = (value - prev_value) mod 2^CNT_W, so counter wrap-around adds the correct positive step.
REQ-017 total (64 bit) SHALL add step every cycle, wrapping mod 2^64.
REQ-018 With INTERVAL>0, an interval counter SHALL count 0..INTERVAL-1 and raise a one-cycle trigger at INTERVAL-1, then return to 0.
REQ-019 trigger or dump_req SHALL set a pending flag; simultaneous trigger and dump_req SHALL produce one pending request.
REQ-020 When pending is set and out_valid is 0, the next edge SHALL set out_valid=1, load out_total=total, out_cycle=cycle_cnt, out_coreid=coreid, out_delta=(value - last_value) mod 2^CNT_W, and clear pending.
REQ-021 out_valid and all out_* fields SHALL hold stable until out_valid and out_ready are both 1 on an edge; that edge clears out_valid and sets last_value to the captured value.
REQ-022 Requests arriving while out_valid is 1 SHALL coalesce into the single pending flag; at most one report follows the handshake.
REQ-023 A request arriving on the handshake cycle SHALL remain pending and capture on the following edge (no lost request).
REQ-024 Latency: request at edge N sets pending; capture at edge N+1 when idle.

Reset
REQ-025 Reset SHALL clear cycle_cnt, total, prev_value, last_value, interval counter, pending, out_valid and all out_* fields to 0, immediately and asynchronously.
REQ-026 Reset asserted mid-report SHALL drop the report without handshake; counting restarts from 0 on deassertion.

Configuration
REQ-027 With LOG_EVENT_DISPLAY_EN defined, each accepted handshake SHALL print "[<out_cycle>] core<out_coreid> <NAME>: total=<out_total> delta=<out_delta>" in decimal.
REQ-028 Without LOG_EVENT_DISPLAY_EN, no simulation printing is compiled; hardware behaviour is identical.

Structure
REQ-029 Package difftest_log_pkg SHALL hold the report struct (coreid, total, delta, cycle), the LogLevel enum (Debug, Info, Warning, Error) and the 64-bit cycle width constant.
REQ-030 One sub-module, log_interval_timer, SHALL implement the INTERVAL counter and trigger; the rest stays in difftest_log_event.

Verification
REQ-031 INTERVAL=4, value +1/cycle from 0, out_ready=1 -> reports every 4 cycles with out_delta=4; out_total increases by 4 per report.
REQ-032 value 0xFFFFFFFE then 0x00000001 -> total step 3, no negative jump in out_total.
REQ-033 out_ready=0 for 20 cycles with INTERVAL=4 -> fields stable, one report pending; after acceptance exactly one more report follows, and its out_delta covers all events since the accepted one.
REQ-034 INTERVAL=0, dump_req pulse at cycle 10 -> out_valid at cycle 12, out_cycle=11; no other reports.
REQ-035 dump_req and trigger on same cycle -> exactly one report.
REQ-036 rst low while out_valid=1 -> out_valid=0 and all outputs 0 immediately; first post-reset report delta counts from value 0.
